// File: rtl/tube_fifo.sv
// Parametrised single-clock byte FIFO for the Tube data registers.
// Supports a runtime one-entry mode, synchronous flush and sticky error flags.
module tube_fifo #(
  parameter int unsigned            WIDTH      = 8,
  parameter int unsigned            DEPTH      = 2,
  parameter logic [WIDTH-1:0]       EMPTY_DATA = WIDTH'(8'hAA)
) (
  input  logic                       clk,
  input  logic                       h_rst_b,
  input  logic                       flush,
  input  logic                       one_byte,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       data_available,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count,
  input  logic                       err_clr,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    cap;
  logic             empty;
  logic             pop;
  logic             wr_accept;

  assign cap            = one_byte ? CW'(1) : CW'(DEPTH);
  assign empty          = (count == '0);
  assign full           = (count >= cap);
  assign data_available = !empty;
  assign rd_data        = empty ? EMPTY_DATA : mem[rd_ptr];

  // A pop frees a slot in the same cycle, so a write alongside it is always accepted.
  assign pop       = rd_en && !empty;
  assign wr_accept = wr_en && ((count < cap) || pop);

  always_ff @(posedge clk) begin
    if (wr_accept && !flush) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge h_rst_b) begin
    if (!h_rst_b) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (wr_accept && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !wr_accept) begin
        count <= count - CW'(1);
      end
      // A fresh error in the same cycle as err_clr keeps its flag set.
      if (wr_en && !wr_accept) begin
        overflow <= 1'b1;
      end else if (err_clr) begin
        overflow <= 1'b0;
      end
      if (rd_en && empty) begin
        underflow <= 1'b1;
      end else if (err_clr) begin
        underflow <= 1'b0;
      end
    end
  end

endmodule
